// File: rtl/cordic_engine.sv
// -----------------------------------------------------------------------------
// cordic_engine
//
// Iterative single-clock CORDIC engine. In rotation mode it rotates (x, y) by
// theta. In vectoring mode it drives y to zero and returns the magnitude (in x)
// and the angle (in theta). A quadrant pre-rotation step gives full +/-pi
// coverage. Magnitudes are not gain-compensated and are scaled by K ~ 1.6468.
// Angles are binary: 2^(WIDTH-1) represents pi.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_ni         asynchronous active-low reset
//   in_valid_i     operands present
//   in_ready_o     engine idle and able to accept (registered)
//   in_mode_i      0 = rotation, 1 = vectoring
//   in_x_i/in_y_i  signed operands, WIDTH bits
//   in_theta_i     signed binary angle, WIDTH bits
//   out_valid_o    result present (registered)
//   out_ready_i    consumer takes the result
//   out_x_o/out_y_o  signed results, saturated to WIDTH bits
//   out_theta_o    signed binary angle result (wraps, no saturation)
// -----------------------------------------------------------------------------
module cordic_engine #(
    parameter int WIDTH = 16,
    parameter int ITERS = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_mode_i,
    input  logic [WIDTH-1:0] in_x_i,
    input  logic [WIDTH-1:0] in_y_i,
    input  logic [WIDTH-1:0] in_theta_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_x_o,
    output logic [WIDTH-1:0] out_y_o,
    output logic [WIDTH-1:0] out_theta_o
);

    // Two bits of headroom above the operand width for the CORDIC gain.
    localparam int IW = WIDTH + 2;
    localparam int CW = $clog2(ITERS);

    localparam logic [WIDTH-1:0]    QUARTER = {2'b01, {(WIDTH-2){1'b0}}};
    localparam logic signed [IW-1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [IW-1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]       LAST_IDX = CW'(ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // atan(2^-i) scaled so that 2^31 = pi, rounded half-up to WIDTH bits.
    function automatic logic [WIDTH-1:0] atan_rom(input logic [CW-1:0] idx);
        logic [4:0]  k;
        logic [31:0] raw;
        logic [32:0] rnd;
        k = 5'(idx);
        case (k)
            5'd0:    raw = 32'd536870912;
            5'd1:    raw = 32'd316933406;
            5'd2:    raw = 32'd167458907;
            5'd3:    raw = 32'd85004756;
            5'd4:    raw = 32'd42667331;
            5'd5:    raw = 32'd21354465;
            5'd6:    raw = 32'd10679838;
            5'd7:    raw = 32'd5340245;
            5'd8:    raw = 32'd2670163;
            5'd9:    raw = 32'd1335087;
            5'd10:   raw = 32'd667544;
            5'd11:   raw = 32'd333772;
            5'd12:   raw = 32'd166886;
            5'd13:   raw = 32'd83443;
            5'd14:   raw = 32'd41722;
            5'd15:   raw = 32'd20861;
            5'd16:   raw = 32'd10430;
            5'd17:   raw = 32'd5215;
            5'd18:   raw = 32'd2608;
            5'd19:   raw = 32'd1304;
            5'd20:   raw = 32'd652;
            5'd21:   raw = 32'd326;
            5'd22:   raw = 32'd163;
            5'd23:   raw = 32'd81;
            5'd24:   raw = 32'd41;
            5'd25:   raw = 32'd20;
            5'd26:   raw = 32'd10;
            5'd27:   raw = 32'd5;
            5'd28:   raw = 32'd3;
            5'd29:   raw = 32'd1;
            5'd30:   raw = 32'd1;
            default: raw = 32'd0;
        endcase
        rnd = {1'b0, raw} + (33'd1 << (31 - WIDTH));
        return rnd[(32-WIDTH) +: WIDTH];
    endfunction

    // Clamp an internal-width value to the signed WIDTH-bit range.
    function automatic logic [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
        logic [WIDTH-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[WIDTH-1:0];
        end else begin
            r = v[WIDTH-1:0];
        end
        return r;
    endfunction

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   mode_q, mode_d;
    logic signed [IW-1:0]   x_q, x_d;
    logic signed [IW-1:0]   y_q, y_d;
    logic [WIDTH-1:0]       z_q, z_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       out_x_q, out_x_d;
    logic [WIDTH-1:0]       out_y_q, out_y_d;
    logic [WIDTH-1:0]       out_theta_q, out_theta_d;

    logic signed [IW-1:0]   x_sh_s, y_sh_s;
    logic [WIDTH-1:0]       rom_s;
    logic                   dir_pos_s;

    assign x_sh_s = x_q >>> cnt_q;
    assign y_sh_s = y_q >>> cnt_q;
    assign rom_s  = atan_rom(cnt_q);
    // d = +1: rotation drives z toward zero, vectoring drives y toward zero.
    assign dir_pos_s = mode_q ? y_q[IW-1] : ~z_q[WIDTH-1];

    // Next-state, datapath and result-register logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_theta_d = out_theta_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    mode_d  = in_mode_i;
                    x_d     = {{2{in_x_i[WIDTH-1]}}, in_x_i};
                    y_d     = {{2{in_y_i[WIDTH-1]}}, in_y_i};
                    z_d     = in_theta_i;
                    cnt_d   = {CW{1'b0}};
                    state_d = S_PRE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                // Fold the operand into the right half-plane so the
                // micro-rotations (total ~99.9 deg) can reach it.
                if (!mode_q) begin
                    if (!z_q[WIDTH-1] && (z_q >= QUARTER)) begin
                        x_d = -y_q;
                        y_d = x_q;
                        z_d = z_q - QUARTER;
                    end else if (z_q[WIDTH-1] && ($signed(z_q) < -$signed({1'b0, QUARTER}))) begin
                        x_d = y_q;
                        y_d = -x_q;
                        z_d = z_q + QUARTER;
                    end else begin
                        z_d = z_q;
                    end
                end else begin
                    if (x_q[IW-1] && !y_q[IW-1]) begin
                        x_d = y_q;
                        y_d = -x_q;
                        z_d = z_q + QUARTER;
                    end else if (x_q[IW-1] && y_q[IW-1]) begin
                        x_d = -y_q;
                        y_d = x_q;
                        z_d = z_q - QUARTER;
                    end else begin
                        z_d = z_q;
                    end
                end
                state_d = S_ITER;
            end
            S_ITER: begin
                if (dir_pos_s) begin
                    x_d = x_q - y_sh_s;
                    y_d = y_q + x_sh_s;
                    z_d = z_q - rom_s;
                end else begin
                    x_d = x_q + y_sh_s;
                    y_d = y_q - x_sh_s;
                    z_d = z_q + rom_s;
                end
                if (cnt_q == LAST_IDX) begin
                    cnt_d       = {CW{1'b0}};
                    state_d     = S_DONE;
                    out_x_d     = sat(x_d);
                    out_y_d     = sat(y_d);
                    out_theta_d = z_d;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State, datapath and registered handshake/result outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            mode_q      <= 1'b0;
            x_q         <= {IW{1'b0}};
            y_q         <= {IW{1'b0}};
            z_q         <= {WIDTH{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= {WIDTH{1'b0}};
            out_y_q     <= {WIDTH{1'b0}};
            out_theta_q <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_theta_q <= out_theta_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_x_o     = out_x_q;
    assign out_y_o     = out_y_q;
    assign out_theta_o = out_theta_q;

endmodule

// File: tb/tb_cordic_engine.sv
// -----------------------------------------------------------------------------
// tb_cordic_engine
//
// Directed bench for cordic_engine (WIDTH=16, ITERS=16). Expected values are
// hand-computed constants with +/-4 LSB tolerance on x/y and +/-3 LSB on theta.
// -----------------------------------------------------------------------------
module tb_cordic_engine;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_mode = 1'b0;
    logic [W-1:0] in_x = '0;
    logic [W-1:0] in_y = '0;
    logic [W-1:0] in_theta = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_x;
    logic [W-1:0] out_y;
    logic [W-1:0] out_theta;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    cordic_engine #(.WIDTH(16), .ITERS(16)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_mode_i  (in_mode),
        .in_x_i     (in_x),
        .in_y_i     (in_y),
        .in_theta_i (in_theta),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_x_o    (out_x),
        .out_y_o    (out_y),
        .out_theta_o(out_theta)
    );

    task automatic check_val(input string tag, input int act, input int exp, input int tol);
        int diff;
        n_total++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, act, exp, tol);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    // Presents operands, waits for the accept edge, then returns in cycle 1.
    task automatic start_op(input logic mode, input int x, input int y, input int th);
        int g;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = mode;
        in_x     = W'(x);
        in_y     = W'(y);
        in_theta = W'(th);
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Garbage operands while busy must not disturb the result.
        in_x     = 16'h5A5A;
        in_y     = 16'hA5A5;
        in_theta = 16'h1234;
        in_mode  = ~mode;
    endtask

    // Counts cycles (accept cycle = 0) until out_valid is seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val({name, ".ovalid_drop"}, int'(out_valid), 0, 0);
        check_val({name, ".irdy_rise"}, int'(in_ready), 1, 0);
    endtask

    task automatic run_op(input string name, input logic mode, input int x, input int y, input int th,
                          input int ex, input int ey, input int et);
        int cyc;
        start_op(mode, x, y, th);
        check_val({name, ".busy_rdy"}, int'(in_ready), 0, 0);
        wait_done(cyc);
        check_val({name, ".latency"}, cyc, 18, 0);
        check_val({name, ".x"}, sx(out_x), ex, 4);
        check_val({name, ".y"}, sx(out_y), ey, 4);
        check_val({name, ".theta"}, sx(out_theta), et, 3);
        release_result(name);
    endtask

    initial begin
        int cyc;
        int sx0, st0;

        // Reset held for 3 cycles.
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("rst.in_ready", int'(in_ready), 0, 0);
            check_val("rst.out_valid", int'(out_valid), 0, 0);
            check_val("rst.outs", int'(out_x | out_y | out_theta), 0, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst.in_ready_after", int'(in_ready), 1, 0);
        check_val("rst.out_valid_after", int'(out_valid), 0, 0);

        run_op("rot45",   1'b0, 9949,   0,     8192,   11585,  11585, 0);
        run_op("rot-135", 1'b0, 9949,   0,    -24576, -11585, -11585, 0);
        run_op("vecQ2",   1'b1, -10000, 10000, 0,      23289,  0,     24576);

        // Saturation with 5 cycles of backpressure.
        start_op(1'b1, 32767, 32767, 0);
        wait_done(cyc);
        check_val("sat.latency", cyc, 18, 0);
        sx0 = sx(out_x);
        st0 = sx(out_theta);
        check_val("sat.x", sx0, 32767, 0);
        check_val("sat.theta", st0, 8192, 3);
        for (int k = 0; k < 5; k++) begin
            check_val("sat.hold_valid", int'(out_valid), 1, 0);
            check_val("sat.hold_x", sx(out_x), 32767, 0);
            check_val("sat.hold_theta", sx(out_theta), st0, 0);
            check_val("sat.hold_rdy", int'(in_ready), 0, 0);
            @(negedge clk);
        end
        release_result("sat");

        // Reset in the middle of ITER (i = 5 is cycle 7).
        start_op(1'b0, 9949, 0, 8192);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst.out_valid", int'(out_valid), 0, 0);
        check_val("midrst.in_ready", int'(in_ready), 0, 0);
        check_val("midrst.outs", int'(out_x | out_y | out_theta), 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("midrst.idle_rdy", int'(in_ready), 1, 0);
        check_val("midrst.no_valid", int'(out_valid), 0, 0);

        run_op("rot45b", 1'b0, 9949, 0, 8192, 11585, 11585, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
